// File: rtl/slink_link_clk_switch_ctrl.sv
// slink_link_clk_switch_ctrl
// Sequencer (refclk domain) that owns the link-clock mux select and the
// link-domain reset request. A clock-source change is always bracketed by
// link reset: assert reset, qualify the PHY clock, flip the select, let the
// synchronized mux settle, then release reset.
//
// Ports:
//   refclk         in   block clock
//   refclk_reset   in   synchronous active-high reset
//   phy_clk_req    in   level request: 1 = link on phy_clk, 0 = link on refclk
//   phy_clk_ready  in   PHY clock valid (asynchronous, synchronized here)
//   use_phy_clk    out  link clock mux select
//   link_reset     out  link-domain reset request (active-high)
//   switch_busy    out  sequence in progress
//   on_phy_clk     out  link running on phy_clk
//   timeout_err    out  sticky PHY-ready timeout flag
//
// state       | meaning
// ------------+---------------------------------------------------------
// INIT        | post-reset hold of link reset, select on refclk
// REF_SETTLE  | select on refclk, waiting for mux to settle
// REF_ACTIVE  | link running on refclk
// RST_TO_PHY  | link reset held before moving to phy_clk
// WAIT_PHY    | waiting for stable phy_clk_ready (bounded by timeout)
// PHY_SETTLE  | select on phy_clk, waiting for mux to settle
// PHY_ACTIVE  | link running on phy_clk
// RST_TO_REF  | link reset held before moving back to refclk
// ERROR       | PHY never became ready; link on refclk, out of reset

module slink_link_clk_switch_ctrl #(
   parameter int RST_CYCLES    = 16,
   parameter int SETTLE_CYCLES = 8,
   parameter int READY_STABLE  = 4,
   parameter int READY_TIMEOUT = 1024,
   parameter int CNT_W         = 16
) (
   input  logic refclk,
   input  logic refclk_reset,
   input  logic phy_clk_req,
   input  logic phy_clk_ready,
   output logic use_phy_clk,
   output logic link_reset,
   output logic switch_busy,
   output logic on_phy_clk,
   output logic timeout_err
);

   typedef enum logic [3:0] {
      S_INIT,
      S_REF_SETTLE,
      S_REF_ACTIVE,
      S_RST_TO_PHY,
      S_WAIT_PHY,
      S_PHY_SETTLE,
      S_PHY_ACTIVE,
      S_RST_TO_REF,
      S_ERROR
   } state_e;

   localparam logic [CNT_W-1:0] RST_LD    = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(READY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] STAB_MAX  = CNT_W'(READY_STABLE - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] stab_q, stab_d;
   logic             rdy_meta_q, rdy_s_q;
   logic             sel_q, sel_d;
   logic             lrst_q, lrst_d;
   logic             busy_q, busy_d;
   logic             on_q, on_d;
   logic             err_q, err_d;
   logic             cnt_zero;
   logic             rdy_ok;

   assign cnt_zero = (cnt_q == '0);

   // stab_q counts preceding consecutive high samples of rdy_s_q, so rdy_ok
   // is true on the READY_STABLE-th consecutive high sample.
   assign rdy_ok = rdy_s_q && (stab_q >= STAB_MAX);

   always_comb begin
      stab_d = stab_q;
      if (!rdy_s_q) begin
         stab_d = '0;
      end else if (stab_q < STAB_MAX) begin
         stab_d = stab_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_zero ? cnt_q : cnt_q - CNT_W'(1);
      case (state_q)
         S_INIT: begin
            if (cnt_zero) begin
               state_d = S_REF_SETTLE;
               cnt_d   = SETTLE_LD;
            end
         end
         S_REF_SETTLE: begin
            if (cnt_zero) state_d = S_REF_ACTIVE;
         end
         S_REF_ACTIVE: begin
            if (phy_clk_req) begin
               state_d = S_RST_TO_PHY;
               cnt_d   = RST_LD;
            end
         end
         S_RST_TO_PHY: begin
            if (cnt_zero) begin
               state_d = S_WAIT_PHY;
               cnt_d   = TMO_LD;
            end
         end
         S_WAIT_PHY: begin
            // request withdrawal wins over readiness, readiness over timeout
            if (!phy_clk_req) begin
               state_d = S_REF_SETTLE;
               cnt_d   = SETTLE_LD;
            end else if (rdy_ok) begin
               state_d = S_PHY_SETTLE;
               cnt_d   = SETTLE_LD;
            end else if (cnt_zero) begin
               state_d = S_ERROR;
            end
         end
         S_PHY_SETTLE: begin
            if (cnt_zero) state_d = S_PHY_ACTIVE;
         end
         S_PHY_ACTIVE: begin
            if (!phy_clk_req || !rdy_s_q) begin
               state_d = S_RST_TO_REF;
               cnt_d   = RST_LD;
            end
         end
         S_RST_TO_REF: begin
            if (cnt_zero) begin
               state_d = S_REF_SETTLE;
               cnt_d   = SETTLE_LD;
            end
         end
         S_ERROR: begin
            if (!phy_clk_req) state_d = S_REF_ACTIVE;
         end
         default: begin
            state_d = S_INIT;
            cnt_d   = RST_LD;
         end
      endcase
   end

   // Outputs are decoded from the next state so they move on the same edge
   // as the state; the select only differs between states that both hold
   // link reset, which keeps every select change inside a reset window.
   always_comb begin
      sel_d  = (state_d == S_PHY_SETTLE) || (state_d == S_PHY_ACTIVE) ||
               (state_d == S_RST_TO_REF);
      lrst_d = !((state_d == S_REF_ACTIVE) || (state_d == S_PHY_ACTIVE) ||
                 (state_d == S_ERROR));
      busy_d = lrst_d;
      on_d   = (state_d == S_PHY_ACTIVE);
      err_d  = err_q || (state_d == S_ERROR);
   end

   always_ff @(posedge refclk) begin
      if (refclk_reset) begin
         state_q    <= S_INIT;
         cnt_q      <= RST_LD;
         stab_q     <= '0;
         rdy_meta_q <= 1'b0;
         rdy_s_q    <= 1'b0;
         sel_q      <= 1'b0;
         lrst_q     <= 1'b1;
         busy_q     <= 1'b1;
         on_q       <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         stab_q     <= stab_d;
         rdy_meta_q <= phy_clk_ready;
         rdy_s_q    <= rdy_meta_q;
         sel_q      <= sel_d;
         lrst_q     <= lrst_d;
         busy_q     <= busy_d;
         on_q       <= on_d;
         err_q      <= err_d;
      end
   end

   assign use_phy_clk = sel_q;
   assign link_reset  = lrst_q;
   assign switch_busy = busy_q;
   assign on_phy_clk  = on_q;
   assign timeout_err = err_q;

endmodule

// File: tb/tb_slink_link_clk_switch_ctrl.sv
// Directed bench for slink_link_clk_switch_ctrl (default parameters).
// Outputs are observed as {use_phy_clk, link_reset, switch_busy,
// on_phy_clk, timeout_err}; inputs change and outputs are sampled on the
// falling edge of refclk.

module tb_slink_link_clk_switch_ctrl;

   logic refclk = 1'b0;
   logic refclk_reset;
   logic phy_clk_req;
   logic phy_clk_ready;
   logic use_phy_clk;
   logic link_reset;
   logic switch_busy;
   logic on_phy_clk;
   logic timeout_err;
   logic [4:0] obs;

   int n_vec = 0;
   int n_err = 0;
   int inv_viol = 0;
   int sel_changes = 0;
   bit mon_en = 1'b0;
   logic prev_sel, prev_lr;

   slink_link_clk_switch_ctrl dut (
      .refclk        (refclk),
      .refclk_reset  (refclk_reset),
      .phy_clk_req   (phy_clk_req),
      .phy_clk_ready (phy_clk_ready),
      .use_phy_clk   (use_phy_clk),
      .link_reset    (link_reset),
      .switch_busy   (switch_busy),
      .on_phy_clk    (on_phy_clk),
      .timeout_err   (timeout_err)
   );

   always #5 refclk = ~refclk;

   assign obs = {use_phy_clk, link_reset, switch_busy, on_phy_clk, timeout_err};

   // select must only move while link reset is held on both sides of the edge
   always @(negedge refclk) begin
      if (mon_en && (use_phy_clk !== prev_sel)) begin
         sel_changes++;
         if (!(prev_lr === 1'b1 && link_reset === 1'b1)) inv_viol++;
      end
      prev_sel = use_phy_clk;
      prev_lr  = link_reset;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      @(negedge refclk);
   endtask

   task automatic test_reset();
      refclk_reset  = 1'b1;
      phy_clk_req   = 1'b0;
      phy_clk_ready = 1'b0;
      repeat (3) @(posedge refclk);
      @(negedge refclk);
      n_vec++;
      if (obs !== 5'b01100) begin n_err++; $display("FAIL reset_state: got %b want 01100", obs); end
      mon_en = 1'b1;
      refclk_reset = 1'b0;
      tick(23);
      n_vec++;
      if (obs !== 5'b01100) begin n_err++; $display("FAIL init_hold_23: got %b want 01100", obs); end
      tick(1);
      n_vec++;
      if (obs !== 5'b00000) begin n_err++; $display("FAIL ref_active_24: got %b want 00000", obs); end
   endtask

   task automatic test_switch_to_phy();
      phy_clk_ready = 1'b1;
      tick(8);
      n_vec++;
      if (obs !== 5'b00000) begin n_err++; $display("FAIL idle_req0: got %b want 00000", obs); end
      phy_clk_req = 1'b1;
      tick(1);
      n_vec++;
      if (obs !== 5'b01100) begin n_err++; $display("FAIL phy_rst_assert: got %b want 01100", obs); end
      tick(16);
      n_vec++;
      if (obs !== 5'b01100) begin n_err++; $display("FAIL wait_phy_e16: got %b want 01100", obs); end
      tick(1);
      n_vec++;
      if (obs !== 5'b11100) begin n_err++; $display("FAIL sel_flip_e17: got %b want 11100", obs); end
      tick(7);
      n_vec++;
      if (obs !== 5'b11100) begin n_err++; $display("FAIL phy_settle_last: got %b want 11100", obs); end
      tick(1);
      n_vec++;
      if (obs !== 5'b10010) begin n_err++; $display("FAIL phy_active_entry: got %b want 10010", obs); end
   endtask

   task automatic test_ready_loss();
      phy_clk_ready = 1'b0;
      tick(2);
      n_vec++;
      if (obs !== 5'b10010) begin n_err++; $display("FAIL loss_in_sync: got %b want 10010", obs); end
      tick(1);
      n_vec++;
      if (obs !== 5'b11100) begin n_err++; $display("FAIL rst_to_ref_entry: got %b want 11100", obs); end
      tick(15);
      n_vec++;
      if (obs !== 5'b11100) begin n_err++; $display("FAIL rst_to_ref_last: got %b want 11100", obs); end
      tick(1);
      n_vec++;
      if (obs !== 5'b01100) begin n_err++; $display("FAIL sel_back_ref: got %b want 01100", obs); end
      tick(7);
      n_vec++;
      if (obs !== 5'b01100) begin n_err++; $display("FAIL ref_settle_last: got %b want 01100", obs); end
      tick(1);
      n_vec++;
      if (obs !== 5'b00000) begin n_err++; $display("FAIL ref_after_loss: got %b want 00000", obs); end
      phy_clk_req = 1'b0;
   endtask

   task automatic test_timeout();
      phy_clk_req = 1'b1;
      tick(1);
      n_vec++;
      if (obs !== 5'b01100) begin n_err++; $display("FAIL tmo_rst_assert: got %b want 01100", obs); end
      tick(1039);
      n_vec++;
      if (obs !== 5'b01100) begin n_err++; $display("FAIL wait_phy_last: got %b want 01100", obs); end
      tick(1);
      n_vec++;
      if (obs !== 5'b00001) begin n_err++; $display("FAIL error_entry: got %b want 00001", obs); end
      tick(3);
      n_vec++;
      if (obs !== 5'b00001) begin n_err++; $display("FAIL error_hold: got %b want 00001", obs); end
      phy_clk_req = 1'b0;
      tick(1);
      n_vec++;
      if (obs !== 5'b00001) begin n_err++; $display("FAIL err_sticky_ref: got %b want 00001", obs); end
   endtask

   task automatic test_glitchy_ready();
      phy_clk_req = 1'b1;
      tick(17);
      n_vec++;
      if (obs !== 5'b01101) begin n_err++; $display("FAIL glitch_wait_entry: got %b want 01101", obs); end
      for (int rep = 0; rep < 5; rep++) begin
         for (int k = 0; k < 4; k++) begin
            phy_clk_ready = (k != 3);
            tick(1);
         end
         n_vec++;
         if (obs !== 5'b01101) begin n_err++; $display("FAIL glitch_rep%0d: got %b want 01101", rep, obs); end
      end
      phy_clk_ready = 1'b1;
      tick(5);
      n_vec++;
      if (obs !== 5'b01101) begin n_err++; $display("FAIL stable_minus1: got %b want 01101", obs); end
      tick(1);
      n_vec++;
      if (obs !== 5'b11101) begin n_err++; $display("FAIL stable_switch: got %b want 11101", obs); end
   endtask

   task automatic test_reset_mid();
      tick(3);
      n_vec++;
      if (obs !== 5'b11101) begin n_err++; $display("FAIL phy_settle_mid: got %b want 11101", obs); end
      refclk_reset = 1'b1;
      tick(1);
      n_vec++;
      if (obs !== 5'b01100) begin n_err++; $display("FAIL reset_mid_settle: got %b want 01100", obs); end
      refclk_reset  = 1'b0;
      phy_clk_req   = 1'b0;
      phy_clk_ready = 1'b0;
      tick(24);
      n_vec++;
      if (obs !== 5'b00000) begin n_err++; $display("FAIL ref_after_reset: got %b want 00000", obs); end
   endtask

   task automatic test_abort();
      // request drop and rdy_ok arrive together: drop must win
      phy_clk_ready = 1'b1;
      tick(8);
      phy_clk_req = 1'b1;
      tick(17);
      n_vec++;
      if (obs !== 5'b01100) begin n_err++; $display("FAIL prio_wait_entry: got %b want 01100", obs); end
      phy_clk_req = 1'b0;
      tick(1);
      n_vec++;
      if (obs !== 5'b01100) begin n_err++; $display("FAIL req_drop_beats_ready: got %b want 01100", obs); end
      tick(7);
      n_vec++;
      if (obs !== 5'b01100) begin n_err++; $display("FAIL prio_settle_last: got %b want 01100", obs); end
      tick(1);
      n_vec++;
      if (obs !== 5'b00000) begin n_err++; $display("FAIL prio_ref_active: got %b want 00000", obs); end
      // plain abort while PHY not ready
      phy_clk_ready = 1'b0;
      tick(3);
      phy_clk_req = 1'b1;
      tick(22);
      n_vec++;
      if (obs !== 5'b01100) begin n_err++; $display("FAIL abort_waiting: got %b want 01100", obs); end
      phy_clk_req = 1'b0;
      tick(1);
      n_vec++;
      if (obs !== 5'b01100) begin n_err++; $display("FAIL abort_wait: got %b want 01100", obs); end
      tick(8);
      n_vec++;
      if (obs !== 5'b00000) begin n_err++; $display("FAIL abort_ref_active: got %b want 00000", obs); end
   endtask

   task automatic test_invariant();
      n_vec++;
      if (inv_viol !== 0) begin n_err++; $display("FAIL sel_outside_reset: got %0d want 0", inv_viol); end
      n_vec++;
      if (sel_changes !== 4) begin n_err++; $display("FAIL sel_change_count: got %0d want 4", sel_changes); end
   endtask

   initial begin
      test_reset();
      test_switch_to_phy();
      test_ready_loss();
      test_timeout();
      test_glitchy_ready();
      test_reset_mid();
      test_abort();
      test_invariant();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
